// File: rtl/pipelined_addsub_if.sv
// Operand/result bundle for pipelined_addsub: the producer offers operations on the
// in_* side, the consumer takes results and status flags on the out_* side.
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             negative;
  logic             overflow;

  modport master (
    output in_valid, mode, a, b, cin, out_ready,
    input  in_ready, out_valid, result, cout, zero, negative, overflow
  );

  modport slave (
    input  in_valid, mode, a, b, cin, out_ready,
    output in_ready, out_valid, result, cout, zero, negative, overflow
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: the carry or borrow ripples through one SLICE-wide chunk per
// stage, and a single global stall lets a full pipeline accept one operation per cycle.
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_addsub_if.slave bus_io
);

  localparam int NSLICE = WIDTH / SLICE;

  if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH (%0d) must be a multiple of SLICE (%0d)", WIDTH, SLICE);
  end

  logic adv;
  logic out_valid_w;

  assign adv              = !out_valid_w || bus_io.out_ready;
  assign bus_io.in_ready  = adv;

  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_stage
    // RW: operand bits still unconsumed entering this stage; OW: result bits known after it.
    localparam int RW = WIDTH - gi * SLICE;
    localparam int OW = (gi + 1) * SLICE;

    logic             vld_d;
    logic             mode_d;
    logic             cin_w;
    logic [RW-1:0]    a_d;
    logic [RW-1:0]    b_d;
    logic [SLICE:0]   sum_w;
    logic [SLICE:0]   dif_w;
    logic [SLICE-1:0] slice_w;
    logic             chain_d;
    logic [OW-1:0]    res_d;

    logic             vld_q;
    logic             chain_q;
    logic [OW-1:0]    res_q;

    if (gi == 0) begin : g_head
      assign vld_d  = bus_io.in_valid && adv;
      assign mode_d = bus_io.mode;
      assign cin_w  = bus_io.cin;
      assign a_d    = bus_io.a;
      assign b_d    = bus_io.b;
      assign res_d  = slice_w;
    end else begin : g_body
      assign vld_d  = g_stage[gi-1].vld_q;
      assign mode_d = g_stage[gi-1].g_fwd.mode_q;
      assign cin_w  = g_stage[gi-1].chain_q;
      assign a_d    = g_stage[gi-1].g_fwd.a_q;
      assign b_d    = g_stage[gi-1].g_fwd.b_q;
      assign res_d  = {slice_w, g_stage[gi-1].res_q};
    end

    // The top bit of the (SLICE+1)-bit difference is the true borrow, not an inverted carry.
    assign sum_w   = {1'b0, a_d[SLICE-1:0]} + {1'b0, b_d[SLICE-1:0]} + {{SLICE{1'b0}}, cin_w};
    assign dif_w   = {1'b0, a_d[SLICE-1:0]} - {1'b0, b_d[SLICE-1:0]} - {{SLICE{1'b0}}, cin_w};
    assign slice_w = mode_d ? dif_w[SLICE-1:0] : sum_w[SLICE-1:0];
    assign chain_d = mode_d ? dif_w[SLICE] : sum_w[SLICE];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q   <= 1'b0;
        chain_q <= 1'b0;
        res_q   <= '0;
      end else if (adv) begin
        vld_q   <= vld_d;
        chain_q <= chain_d;
        res_q   <= res_d;
      end
    end

    if (gi < NSLICE - 1) begin : g_fwd
      logic             mode_q;
      logic [RW-SLICE-1:0] a_q;
      logic [RW-SLICE-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mode_q <= 1'b0;
          a_q    <= '0;
          b_q    <= '0;
        end else if (adv) begin
          mode_q <= mode_d;
          a_q    <= a_d[RW-1:SLICE];
          b_q    <= b_d[RW-1:SLICE];
        end
      end
    end else begin : g_tail
      logic a_msb;
      logic b_msb;
      logic zero_d;
      logic neg_d;
      logic ovf_d;
      logic zero_q;
      logic neg_q;
      logic ovf_q;

      // The last operand slice still carries both operand sign bits.
      assign a_msb  = a_d[RW-1];
      assign b_msb  = b_d[RW-1];
      assign zero_d = (res_d == '0);
      assign neg_d  = res_d[OW-1];
      assign ovf_d  = mode_d ? ((a_msb != b_msb) && (res_d[OW-1] != a_msb))
                             : ((a_msb == b_msb) && (res_d[OW-1] != a_msb));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (adv) begin
          zero_q <= zero_d;
          neg_q  <= neg_d;
          ovf_q  <= ovf_d;
        end
      end
    end
  end

  assign out_valid_w      = g_stage[NSLICE-1].vld_q;
  assign bus_io.out_valid = out_valid_w;
  assign bus_io.result    = g_stage[NSLICE-1].res_q;
  assign bus_io.cout      = g_stage[NSLICE-1].chain_q;
  assign bus_io.zero      = g_stage[NSLICE-1].g_tail.zero_q;
  assign bus_io.negative  = g_stage[NSLICE-1].g_tail.neg_q;
  assign bus_io.overflow  = g_stage[NSLICE-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: a 16/4 and a 32/8 instance checked every cycle against an
// arithmetic model with an in-order queue, plus directed literal cases.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(16)) if16 ();
  pipelined_addsub_if #(.WIDTH(32)) if32 ();

  pipelined_addsub #(.WIDTH(16), .SLICE(4)) dut16 (.clk(clk), .rst(rst), .bus_io(if16));
  pipelined_addsub #(.WIDTH(32), .SLICE(8)) dut32 (.clk(clk), .rst(rst), .bus_io(if32));

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  flags;     // {cout, zero, negative, overflow}
    longint      ready_at;  // advance count after which the op sits at the output
  } exp_t;

  exp_t        q [2][$];
  longint      adv_cnt [2];
  logic        prev_stall [2];
  logic [63:0] prev_res [2];
  logic [3:0]  prev_flags [2];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Plain integer arithmetic: signed overflow is "true signed result out of range".
  function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b, logic ci, logic md);
    exp_t            e;
    longint unsigned mask, ua, ub, full, uci;
    longint          sa, sb, sr, lim;
    logic            c, z, n, o;
    mask = (64'd1 << w) - 64'd1;
    ua   = a & mask;
    ub   = b & mask;
    uci  = {63'd0, ci};
    if (md) begin
      full = ua - ub - uci;
      c    = (ua < ub + uci);
    end else begin
      full = ua + ub + uci;
      c    = ((full >> w) != 64'd0);
    end
    e.res = full & mask;
    sa  = ((ua >> (w - 1)) != 64'd0) ? longint'(ua) - longint'(mask) - 64'sd1 : longint'(ua);
    sb  = ((ub >> (w - 1)) != 64'd0) ? longint'(ub) - longint'(mask) - 64'sd1 : longint'(ub);
    sr  = md ? sa - sb - longint'(uci) : sa + sb + longint'(uci);
    lim = 64'sd1 <<< (w - 1);
    o   = (sr >= lim) || (sr < -lim);
    z   = (e.res == 64'd0);
    n   = ((e.res >> (w - 1)) & 64'd1) != 64'd0;
    e.flags    = {c, z, n, o};
    e.ready_at = 0;
    return e;
  endfunction

  task automatic mon(int id, int w, int ns, logic ov, logic ir, logic iv, logic ordy,
                     logic md, logic ci, logic [63:0] av, logic [63:0] bv,
                     logic [63:0] rv, logic [3:0] fl);
    exp_t  e;
    logic  exp_ov, adv_m;
    string tag;
    tag = (id == 0) ? "w16" : "w32";
    if (rst) begin
      chk({tag, "_rst_out_valid"}, 64'(ov), 64'd0);
      chk({tag, "_rst_result"}, rv, 64'd0);
      chk({tag, "_rst_flags"}, 64'(fl), 64'd0);
      chk({tag, "_rst_in_ready"}, 64'(ir), 64'd1);
      q[id].delete();
      prev_stall[id] = 1'b0;
      return;
    end
    exp_ov = (q[id].size() > 0) && (q[id][0].ready_at <= adv_cnt[id]);
    chk({tag, "_out_valid"}, 64'(ov), 64'(exp_ov));
    chk({tag, "_in_ready"}, 64'(ir), 64'(!exp_ov || ordy));
    if (exp_ov && ov) begin
      chk({tag, "_result"}, rv, q[id][0].res);
      chk({tag, "_flags"}, 64'(fl), 64'(q[id][0].flags));
    end
    if (prev_stall[id]) begin
      chk({tag, "_stall_result"}, rv, prev_res[id]);
      chk({tag, "_stall_flags"}, 64'(fl), 64'(prev_flags[id]));
    end
    prev_stall[id] = ov && !ordy;
    prev_res[id]   = rv;
    prev_flags[id] = fl;
    adv_m = !exp_ov || ordy;
    if (adv_m) begin
      if (exp_ov) void'(q[id].pop_front());
      adv_cnt[id]++;
      if (iv) begin
        e = model(w, av, bv, ci, md);
        e.ready_at = adv_cnt[id] + longint'(ns) - 1;
        q[id].push_back(e);
      end
    end
  endtask

  always @(negedge clk)
    mon(0, 16, 4, if16.out_valid, if16.in_ready, if16.in_valid, if16.out_ready, if16.mode,
        if16.cin, 64'(if16.a), 64'(if16.b), 64'(if16.result),
        {if16.cout, if16.zero, if16.negative, if16.overflow});

  always @(negedge clk)
    mon(1, 32, 4, if32.out_valid, if32.in_ready, if32.in_valid, if32.out_ready, if32.mode,
        if32.cin, 64'(if32.a), 64'(if32.b), 64'(if32.result),
        {if32.cout, if32.zero, if32.negative, if32.overflow});

  task automatic set_in(int id, logic v, logic md, logic [63:0] av, logic [63:0] bv, logic ci);
    if (id == 0) begin
      if16.in_valid = v; if16.mode = md; if16.a = av[15:0]; if16.b = bv[15:0]; if16.cin = ci;
    end else begin
      if32.in_valid = v; if32.mode = md; if32.a = av[31:0]; if32.b = bv[31:0]; if32.cin = ci;
    end
  endtask

  task automatic set_ordy(int id, logic r);
    if (id == 0) if16.out_ready = r;
    else         if32.out_ready = r;
  endtask

  task automatic get_out(int id, output logic ov, output logic [63:0] rv, output logic [3:0] fl);
    if (id == 0) begin
      ov = if16.out_valid; rv = 64'(if16.result);
      fl = {if16.cout, if16.zero, if16.negative, if16.overflow};
    end else begin
      ov = if32.out_valid; rv = 64'(if32.result);
      fl = {if32.cout, if32.zero, if32.negative, if32.overflow};
    end
  endtask

  function automatic logic [63:0] pick(int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return mask;
      2:       return 64'd1 << (w - 1);
      3:       return (64'd1 << (w - 1)) - 64'd1;
      4:       return 64'd1;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  // One op into an idle pipeline; checks latency and literal result/flags.
  task automatic directed(int id, string nm, logic md, logic [63:0] av, logic [63:0] bv,
                          logic ci, logic [63:0] er, logic [3:0] efl);
    logic        ov;
    logic [63:0] rv;
    logic [3:0]  fl;
    int          lat;
    set_ordy(id, 1'b1);
    set_in(id, 1'b1, md, av, bv, ci);
    @(posedge clk); #1;
    set_in(id, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    lat = 1;
    get_out(id, ov, rv, fl);
    while (!ov && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      get_out(id, ov, rv, fl);
    end
    chk({nm, "_latency"}, 64'(lat), 64'd4);
    chk({nm, "_result"}, rv, er);
    chk({nm, "_flags"}, 64'(fl), 64'(efl));
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic        ov;
  logic [63:0] rv;
  logic [3:0]  fl;
  int          first, last, nov, sent, got;
  logic [15:0] pa [6];
  logic [15:0] pb [6];
  logic        pm [6];
  logic        pc [6];

  initial begin
    for (int i = 0; i < 2; i++) begin
      adv_cnt[i] = 0; prev_stall[i] = 1'b0; prev_res[i] = 64'd0; prev_flags[i] = 4'd0;
      set_in(i, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
      set_ordy(i, 1'b1);
    end
    #2 rst = 1'b1;
    set_in(0, 1'b1, 1'b0, 64'h1234, 64'h1, 1'b0);
    set_in(1, 1'b1, 1'b1, 64'h5, 64'h9, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    set_in(0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    set_in(1, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    directed(0, "sub_12345_54321", 1'b1, 64'd12345, 64'd54321, 1'b0, 64'd23560, 4'b1000);
    directed(0, "sub_1_2_bin",     1'b1, 64'd1,     64'd2,     1'b1, 64'd65534, 4'b1010);
    directed(0, "add_ffff_1",      1'b0, 64'hFFFF,  64'h1,     1'b0, 64'h0,     4'b1100);
    directed(0, "add_7fff_1",      1'b0, 64'h7FFF,  64'h1,     1'b0, 64'h8000,  4'b0011);
    directed(0, "sub_8000_1",      1'b1, 64'h8000,  64'h1,     1'b0, 64'h7FFF,  4'b0001);
    directed(0, "sub_equal",       1'b1, 64'h1234,  64'h1234,  1'b0, 64'h0,     4'b0100);
    directed(1, "w32_sub_0_1",     1'b1, 64'h0,     64'h1,     1'b0, 64'hFFFFFFFF, 4'b1010);

    // Back-to-back stream, alternating mode.
    first = 0; last = 0; nov = 0;
    set_ordy(0, 1'b1);
    for (int t = 1; t <= 20; t++) begin
      if (t <= 8) set_in(0, 1'b1, (t % 2) == 0, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)));
      else        set_in(0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
      @(posedge clk); #1;
      get_out(0, ov, rv, fl);
      if (ov) begin
        nov++;
        if (first == 0) first = t;
        last = t;
      end
    end
    chk("stream_first_edge", 64'(first), 64'd4);
    chk("stream_count", 64'(nov), 64'd8);
    chk("stream_span", 64'(last - first + 1), 64'd8);

    // Backpressure: out_ready low for three cycles while results are waiting.
    for (int i = 0; i < 6; i++) begin
      pa[i] = 16'($urandom); pb[i] = 16'($urandom);
      pm[i] = 1'($urandom_range(0, 1)); pc[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; got = 0;
    for (int c = 1; c <= 30; c++) begin
      set_ordy(0, !(c >= 6 && c <= 8));
      if (sent < 6) set_in(0, 1'b1, pm[sent], 64'(pa[sent]), 64'(pb[sent]), pc[sent]);
      else          set_in(0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
      @(negedge clk);
      if (c >= 6 && c <= 8) begin
        chk("bp_out_valid_held", 64'(if16.out_valid), 64'd1);
        chk("bp_in_ready_low", 64'(if16.in_ready), 64'd0);
      end
      if (if16.in_valid && if16.in_ready) sent++;
      if (if16.out_valid && if16.out_ready) got++;
      @(posedge clk); #1;
    end
    chk("bp_sent", 64'(sent), 64'd6);
    chk("bp_retired", 64'(got), 64'd6);

    // Reset with the first op at the output and three more in flight.
    set_ordy(0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1'b1, 1'($urandom_range(0, 1)), 64'($urandom), 64'($urandom), 1'b0);
      @(posedge clk); #1;
    end
    set_in(0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    get_out(0, ov, rv, fl);
    chk("midrst_pre_out_valid", 64'(ov), 64'd1);
    rst = 1'b1;
    #1;
    get_out(0, ov, rv, fl);
    chk("midrst_out_valid", 64'(ov), 64'd0);
    chk("midrst_result", rv, 64'd0);
    chk("midrst_flags", 64'(fl), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    nov = 0;
    repeat (12) begin
      @(posedge clk); #1;
      get_out(0, ov, rv, fl);
      if (ov) nov++;
    end
    chk("midrst_nothing_emitted", 64'(nov), 64'd0);

    // Random traffic on both widths with random backpressure and corner operands.
    for (int c = 0; c < 400; c++) begin
      for (int id = 0; id < 2; id++) begin
        set_in(id, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               pick(id == 0 ? 16 : 32), pick(id == 0 ? 16 : 32), 1'($urandom_range(0, 1)));
        set_ordy(id, $urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
    end
    for (int id = 0; id < 2; id++) begin
      set_in(id, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
      set_ordy(id, 1'b1);
    end
    repeat (20) @(posedge clk);
    #1;
    chk("w16_drained", 64'(q[0].size()), 64'd0);
    chk("w32_drained", 64'(q[1].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined add/subtract unit for the ALU datapath.
- Generalises the registered 16-bit slice-chained subtractor to any WIDTH, with selectable add or subtract mode per operation.
- The carry/borrow ripples through one SLICE-wide chunk per pipeline stage, so a new operation can be accepted every cycle.
- Provides valid/ready flow control plus carry/borrow, zero, negative and signed-overflow flags for the future status register.

Parameters:
- WIDTH, 16, operand and result width in bits.
- SLICE, 4, bits resolved per pipeline stage. WIDTH must be a multiple of SLICE; otherwise elaboration fails with $error.
- NSLICE, WIDTH/SLICE, derived; pipeline depth. Not to be overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation offered this cycle.
- in_ready  output  1  unit can accept an operation this cycle.
- mode  input  1  0 = add (a+b+cin), 1 = subtract (a-b-cin).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; borrow-in for subtract.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  output  1  add: carry-out; sub: borrow-out (1 iff a < b+cin, unsigned).
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rst=1, asynchronous): every stage valid bit, result, cout, zero, negative and overflow go to 0 immediately. in_ready=1 while rst=1 is ignored; no transfer is accepted during reset.
- Reset mid-operation: all in-flight operations are discarded; nothing is emitted afterwards.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - Input transfer occurs when in_valid && in_ready.
  - When adv=0, every stage register holds its value.
- Stage k (k = 0..NSLICE-1) on adv:
  - Computes slice k of the result from the slice-k operands and the chain bit from stage k-1 (stage 0 uses cin).
  - Registers that partial result and the chain bit.
  - Forwards mode, the not-yet-consumed operand slices and the completed lower result slices to stage k+1.
  - A stage's valid bit loads the valid bit of the stage before it (stage 0 loads in_valid && in_ready).
  - Bubbles propagate as valid=0; data registers of bubble stages are don't-care.
- Latency:
  - Counting the accepting edge as edge 1, out_valid=1 after edge NSLICE (4 for defaults).
  - Throughput is 1 op/cycle when out_ready=1.
  - Operation order is preserved.
- Flags are registered with the last stage, computed from the full result and the operand MSBs carried along:
  - zero = (result==0).
  - negative = result MSB.
  - Add overflow = (a_msb==b_msb) && (res_msb!=a_msb).
  - Sub overflow = (a_msb!=b_msb) && (res_msb!=a_msb).
- Subtract is implemented as a true borrow chain, so cout is the borrow, not an inverted carry.
- Backpressure:
  - When out_valid=1 and out_ready=0, result and flags stay stable and in_ready=0.
  - No accepted operation is lost or duplicated.
  - Pipeline bubbles are not collapsed (simple global stall).
- Simultaneous pop and push: if out_valid && out_ready && in_valid, the output retires and the new op enters stage 0 on the same edge.
- SLICE==WIDTH: degenerates to a single registered stage with latency 1.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_valid=1 → out_valid=0, all outputs 0. Release rst → first accepted op emerges after 4 edges.
- Subtract: a=12345, b=54321, cin=0 → result=23560, cout=1, zero=0, negative=0, overflow=0. Then a=1, b=2, cin=1 → result=65534, cout=1, negative=1, overflow=0.
- Add edge cases:
  - a=65535, b=1 → result=0, cout=1, zero=1, overflow=0.
  - a=0x7FFF, b=1 → result=0x8000, negative=1, overflow=1.
  - Subtract a=0x8000, b=1 → result=0x7FFF, cout=0, overflow=1.
- Streaming: 8 back-to-back ops with alternating mode and out_ready=1 → 8 consecutive out_valid cycles, in order, starting 4 edges after the first.
- Backpressure: stream 6 ops, drop out_ready for 3 cycles mid-stream → result stable and in_ready=0 during stall; all 6 results appear exactly once, in order.
- Reset mid-flight and parameter sweep:
  - Assert rst with 3 ops in flight → out_valid=0 immediately, none of them emitted later.
  - Repeat with WIDTH=32, SLICE=8: 0x00000000-0x00000001 → 0xFFFFFFFF, cout=1, latency 4.
